// File: rtl/lw.sv
// Single-cycle load-word core. Each rising edge executes the instruction
// fetched from the internal ROM at pc and advances pc by 4. Only lw
// (op 6'b100011) writes the register file. Every other opcode is a NOP.
module lw (
    input  logic clk,
    input  logic rst
);

    localparam logic [5:0] OP_LW = 6'b100011;

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] regs [0:31];
    logic [31:0] imem [0:31];
    logic [31:0] dmem [0:63];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ea;
    logic [31:0] load_data;
    logic        reg_we;

    // Only ea[7:2] selects a data word. The other address bits and the
    // second read port have no consumer in this load-only datapath.
    logic unused_bits;
    assign unused_bits = ^{ea[31:8], ea[1:0], rt_data};

    // Build a lw encoding from its fields.
    function automatic logic [31:0] enc_lw(input logic [4:0] base, input logic [4:0] dst,
                                           input logic [15:0] ofs);
        return {OP_LW, base, dst, ofs};
    endfunction

    // Instruction ROM. Words without a program entry hold 0 and run as a NOP.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            imem[i] = 32'h0000_0000;
        end
        imem[0] = enc_lw(5'd0, 5'd1, 16'd4);
        imem[1] = enc_lw(5'd1, 5'd2, 16'd4);
        imem[2] = enc_lw(5'd2, 5'd3, 16'd8);
        imem[3] = enc_lw(5'd3, 5'd4, 16'hfffc);
        imem[4] = enc_lw(5'd4, 5'd5, 16'd0);
        imem[5] = enc_lw(5'd0, 5'd0, 16'd8);
        imem[6] = enc_lw(5'd0, 5'd6, 16'd252);
        imem[7] = enc_lw(5'd0, 5'd7, 16'd256);
        imem[8] = enc_lw(5'd1, 5'd8, 16'd2);
    end

    // Data ROM holding word i = 4*i. It is never written and reset does
    // not touch it.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            dmem[i] = 32'(i) << 2;
        end
    end

    // Fetch and decode.
    assign instr = imem[pc[6:2]];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign imm   = instr[15:0];

    // Two combinational read ports. Register 0 always reads as zero.
    assign rs_data = regs[rs];
    assign rt_data = regs[rt];

    // Effective address is a wrapping add with the sign-extended offset.
    assign ea        = rs_data + {{16{imm[15]}}, imm};
    assign load_data = dmem[ea[7:2]];
    assign reg_we    = (op == OP_LW) && (rt != 5'd0);

    // Program counter: advances by one word every cycle and wraps through the ROM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 32'd0;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    // Register file write port. Writes to register 0 are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (reg_we) begin
            regs[rt] <= load_data;
        end
    end

endmodule

// File: tb/tb_lw.sv
// Bench for the load-word core. A behavioural model executes the program
// from its assembly listing and is compared against the core's pc, instr
// and register file after every edge and across asynchronous resets.
module tb_lw;

    logic clk;
    logic rst;

    int checks;
    int errors;

    lw dut (
        .clk (clk),
        .rst (rst)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_regs [0:31];
    logic [31:0] m_imem [0:31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Program listing as (rt, offset, rs) rows, as written in assembly.
    task automatic model_load_program();
        int rt_t[9]  = '{1, 2, 3, 4, 5, 0, 6, 7, 8};
        int ofs_t[9] = '{4, 4, 8, -4, 0, 8, 252, 256, 2};
        int rs_t[9]  = '{0, 1, 2, 3, 4, 0, 0, 0, 1};
        for (int i = 0; i < 32; i++) m_imem[i] = 32'h0;
        for (int i = 0; i < 9; i++) begin
            m_imem[i] = (32'h23 << 26) | (32'(rs_t[i]) << 21) | (32'(rt_t[i]) << 16)
                        | (32'(ofs_t[i]) & 32'hffff);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic [31:0] ea;
        int          rsi;
        int          rti;
        int          ofs;
        w   = m_imem[(m_pc / 4) % 32];
        rsi = int'((w >> 21) & 32'h1f);
        rti = int'((w >> 16) & 32'h1f);
        ofs = int'(w & 32'hffff);
        if (ofs >= 32768) ofs = ofs - 65536;
        if ((w >> 26) == 32'h23) begin
            ea = m_regs[rsi] + 32'(ofs);
            if (rti != 0) m_regs[rti] = 4 * ((ea / 4) % 64);
        end
        m_pc = m_pc + 4;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":pc"}, dut.pc, m_pc);
        check({tag, ":instr"}, dut.instr, m_imem[(m_pc / 4) % 32]);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s:r%0d", tag, i), dut.regs[i], m_regs[i]);
        end
    endtask

    // Driver: one rising edge, then update the model and compare on the falling edge.
    task automatic run_edge(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    // Driver: assert reset asynchronously partway through the low phase of clk.
    task automatic async_reset(input int hold_cycles);
        #($urandom_range(1, 3));
        rst = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        compare_all("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_load_program();
        model_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all("reset");
        check("reset_instr", dut.instr, 32'h8C01_0004);
        rst = 1'b1;

        // Full program plus a wrap of the ROM, with fixed spot checks.
        for (int e = 1; e <= 40; e++) begin
            run_edge($sformatf("edge%0d", e));
            case (e)
                1: begin check("e1_r1", dut.regs[1], 32'd4); check("e1_pc", dut.pc, 32'd4); end
                5: begin
                    check("e5_r2", dut.regs[2], 32'd8);
                    check("e5_r3", dut.regs[3], 32'd16);
                    check("e5_r4", dut.regs[4], 32'd12);
                    check("e5_r5", dut.regs[5], 32'd12);
                    check("e5_pc", dut.pc, 32'd20);
                end
                6: check("e6_r0", dut.regs[0], 32'd0);
                7: check("e7_r6", dut.regs[6], 32'd252);
                8: check("e8_r7", dut.regs[7], 32'd0);
                9: check("e9_r8", dut.regs[8], 32'd4);
                32: check("e32_instr", dut.instr, 32'h8C01_0004);
                default: ;
            endcase
        end

        // Reset between edges 4 and 5 of a fresh run.
        async_reset(2);
        for (int e = 1; e <= 4; e++) run_edge("pre_mid");
        async_reset(1);
        run_edge("post_mid");
        check("mid_r1", dut.regs[1], 32'd4);

        // Randomised run lengths and reset holds.
        for (int k = 0; k < 12; k++) begin
            int n;
            n = $urandom_range(1, 45);
            for (int e = 0; e < n; e++) run_edge($sformatf("rnd%0d", k));
            async_reset($urandom_range(0, 3));
        end
        for (int e = 0; e < 10; e++) run_edge("tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lw.md
# lw

Single-cycle load-word processor core: fetches one 32-bit MIPS-format instruction per clock from an internal instruction ROM and executes `lw rt, imm(rs)` in that same cycle. It uses an internal register file, a sign-extended address adder and a data ROM. It is the lw-only slice of the single-cycle processor and has no external data ports; it is verified through its internal state.

## Interface
- No parameters; sizes are fixed. The instruction ROM is 32 words, the data memory is 64 words and the register file is 32 × 32.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- Required internal observation names:
  - `pc` (32 b)
  - `instr` (32 b)
  - `regs[0:31]` (32 b each)
  - `dmem[0:63]` (32 b each)

## Operation
- Fetch: `instr = imem[pc[6:2]]`, combinational.
- Instruction ROM program (word index: instruction):
  - 0: lw $1,4($0)
  - 1: lw $2,4($1)
  - 2: lw $3,8($2)
  - 3: lw $4,-4($3)
  - 4: lw $5,0($4)
  - 5: lw $0,8($0)
  - 6: lw $6,252($0)
  - 7: lw $7,256($0)
  - 8: lw $8,2($1)
  - 9–31: 32'h0000_0000, executed as NOP.
- Decode fields:
  - op=instr[31:26]
  - rs=instr[25:21]
  - rt=instr[20:16]
  - imm=instr[15:0]
- Only op=6'b100011 (lw) performs a write. Every other opcode, including all-zero, is a NOP: no register write, PC still advances.
- Address: ea = regs[rs] + sign_extend(imm), 32-bit wrapping add.
- Data memory:
  - Word-addressed by ea[7:2].
  - Bits ea[31:8] and ea[1:0] are ignored; misaligned addresses truncate and out-of-range addresses wrap.
  - Contents are initialised to dmem[i] = 4*i.
  - Never written and not affected by reset.
- Writeback: regs[rt] ← dmem[ea[7:2]] when the instruction is lw and rt≠0.
  - regs[0] always reads 0; a write to it is discarded.
- Register reads are combinational, two read ports (rs, rt), one write port.
- Next PC is pc+4 every cycle. Because fetch uses pc[6:2], the program repeats after word 31.

## Timing
- Reset (rst=0), applied asynchronously:
  - pc=0.
  - regs[0..31]=0.
  - Held for as long as rst is low; no register writes occur while in reset.
- First rising clk edge after rst goes high: executes imem[0] and sets pc=4.
- Latency: an instruction fetched at pc commits its register write and pc+4 on the same rising edge (1 cycle per instruction).
- A value loaded on edge N is visible to the instruction executing in cycle N+1 (back-to-back dependency, no stall, no forwarding needed).
- Reset asserted mid-program: pc and regs clear immediately. The write of the instruction in flight is lost and dmem is unchanged.
- No hazards or multi-cycle states; the design has no FSM beyond the PC register.

## Test plan
- Reset: hold rst=0 with clk toggling.
  - Required: pc=0 and all regs=0, instr=lw $1,4($0) (32'h8C01_0004).
  - Release, one edge: regs[1]=4, pc=4.
- Dependent chain: after edges 2–5:
  - regs[2]=8, regs[3]=16, regs[4]=12, regs[5]=12.
  - pc=20.
- $0 protection: after edge 6, regs[0]=0 and regs[1..5] are unchanged.
- Address boundary and wrap:
  - After edge 7: regs[6]=252 (dmem[63]).
  - After edge 8: regs[7]=0 (ea=256 wraps to dmem[0]).
- Misalignment and NOP:
  - After edge 9: regs[8]=4 (ea=6 truncates to dmem[1]).
  - Edges 10–32: no register changes; pc wraps so that instr at edge 33 is again lw $1,4($0).
- Asynchronous reset mid-run: drop rst between edges 4 and 5 without a clock edge.
  - Required: pc=0 and regs all 0 immediately.
  - After release, one edge: regs[1]=4.
